mux_scan_controller: RTL and testbench
======================================

# mux_scan_controller

Sequencer sitting directly upstream of the 16:1 single-bit mux. It drives the mux's 4-bit select through all 16 channels. After a programmable settle time per channel it samples the mux output, and it assembles one 16-bit snapshot word per scan. A start/busy/done handshake lets a host trigger scans.

## Interface
- `DWELL_W`, default 8: width of the per-channel settle count.
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: scan request, accepted only in IDLE.
- `dwell`, in, `DWELL_W`: settle cycles per channel, latched at start.
- `mask`, in, 16: channel enable, latched at start. Present only with `SCAN_MASK_EN`.
- `sel`, out, 4: select to the mux.
- `y_in`, in, 1: mux output, sampled in SAMPLE.
- `busy`, out, 1: high from start acceptance until the scan completes.
- `done`, out, 1: one-cycle pulse at scan completion.
- `data_out`, out, 16: bit k = sample of channel k from the last completed scan. Held until the next completion.

## Operation
- States: IDLE, SETTLE, SAMPLE.
- IDLE, start=1:
  - Latch `dwell` into D, load cnt=D.
  - sel←first channel (0, or the lowest enabled channel with the mask).
  - busy←1.
  - Next state is SETTLE if D≠0, otherwise SAMPLE.
- start while busy: ignored. No queuing.
- SETTLE:
  - cnt decrements each cycle.
  - Leave for SAMPLE on the cycle cnt==1, so SETTLE lasts exactly D cycles.
- SAMPLE:
  - Write y_in into shadow[sel].
  - If sel is not the last channel: sel←next channel, cnt←D, go to SETTLE (or SAMPLE if D=0).
  - If sel is the last channel: data_out←shadow with the current y_in merged in, done←1 for one cycle, busy←0, return to IDLE.
- sel changes only on state-transition edges and is stable throughout SETTLE and SAMPLE.
- In IDLE, sel holds its last value.
- data_out is updated atomically, only at completion, never partially.

## Timing
- Reset values: sel=0, busy=0, done=0, data_out=0, state=IDLE, cnt=0, shadow=0.
- Per channel: D+1 cycles. Full scan: 16·(D+1) cycles.
  - Counted from the start-accept edge to the edge at which done and data_out update.
  - D=0 → 16 cycles. D=255 → 4096 cycles.
- done rises in the same cycle that busy falls and data_out changes.
- start may be asserted in the cycle done is high. In that cycle the FSM is already IDLE, so start is accepted and busy is high again the next cycle.
- Reset mid-scan:
  - Abort immediately.
  - All outputs return to their reset values, including data_out→0.
  - No done pulse.
- dwell changing mid-scan has no effect, because D is latched at start.

## Configuration
- `SCAN_MASK_EN` defined:
  - The `mask` port exists and is latched at start.
  - Disabled channels are skipped: sel advances to the next enabled channel.
  - The data_out bit of a disabled channel is 0.
  - Last channel = highest enabled channel.
  - All-zero mask: busy for one cycle, then done pulses with data_out=0. Exactly 1 cycle from accept to done.
- `SCAN_MASK_EN` undefined:
  - No `mask` port.
  - All 16 channels are scanned in order 0→15.
  - No skip logic is synthesised.

## Structure
- Shared package holds:
  - NUM_CH=16 and SEL_W=4.
  - The state enum (IDLE, SETTLE, SAMPLE).
- One sub-module `scan_next_ch` (combinational priority search): given the current sel and the latched mask, it returns the next enabled channel index and a last flag.
  - Without the macro it reduces to sel+1, with last = (sel==15).

## Test plan
- Reset, then hold idle → sel=0, busy=0, done=0, data_out=0.
- y_in driven from a 16-bit pattern indexed by sel, pattern 0xA5C3, D=0 → done exactly 16 cycles after accept, data_out=0xA5C3.
- D=3, pattern 0x8001 → sel is held 4 cycles per channel, done at 64 cycles, data_out=0x8001. A start pulse mid-scan is ignored.
- rst asserted at cycle 20 of a D=2 scan → next cycle all outputs are 0 and there is no done. A restart then completes normally in 48 cycles.
- Back-to-back: start asserted in the done cycle → a new scan begins and busy is high the next cycle.
- With `SCAN_MASK_EN`:
  - mask=0x0101, D=1, pattern 0xFFFF → sel visits only 0 then 8, done at 4 cycles, data_out=0x0101.
  - mask=0 → done 1 cycle after accept, data_out=0.

Source files
------------

// File: rtl/mux_scan_controller_pkg.sv
// Shared definitions for the mux scan controller.
//   NUM_CH / SEL_W : channel count of the downstream mux and its select width.
//   ST_*           : FSM state encodings (IDLE, SETTLE, SAMPLE).
//   first_ch()     : lowest enabled channel of a mask (0 when none is enabled).
package mux_scan_controller_pkg;

  localparam int NUM_CH = 16;
  localparam int SEL_W  = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;

  function automatic logic [SEL_W-1:0] first_ch(input logic [NUM_CH-1:0] mask);
    first_ch = '0;
    // Descending walk so the lowest set bit is the one that sticks.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i]) first_ch = SEL_W'(i);
    end
  endfunction

endpackage

// File: rtl/mux_scan_controller_scan_next_ch.sv
// scan_next_ch: combinational search for the channel that follows i_sel.
// Optional feature macro: SCAN_MASK_EN (adds i_mask and the skip search).
// Ports:
//   i_sel  : currently selected channel
//   i_mask : latched channel enables (SCAN_MASK_EN only)
//   o_next : next channel to visit
//   o_last : no further channel follows i_sel
module scan_next_ch
  import mux_scan_controller_pkg::*;
(
  input  logic [SEL_W-1:0]  i_sel,
`ifdef SCAN_MASK_EN
  input  logic [NUM_CH-1:0] i_mask,
`endif
  output logic [SEL_W-1:0]  o_next,
  output logic              o_last
);

`ifdef SCAN_MASK_EN
  always_comb begin
    o_next = '0;
    o_last = 1'b1;
    // Descending walk: the lowest enabled channel above i_sel wins.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (i_mask[i] && (i > int'(i_sel))) begin
        o_next = SEL_W'(i);
        o_last = 1'b0;
      end
    end
  end
`else
  always_comb begin
    o_next = i_sel + SEL_W'(1);
    o_last = (i_sel == SEL_W'(NUM_CH - 1));
  end
`endif

endmodule

// File: rtl/mux_scan_controller.sv
// mux_scan_controller: steps the select of a 16:1 single-bit mux through its
// channels, waits a programmable settle time on each, samples the mux output
// and publishes one 16-bit snapshot per scan.
// Optional feature macro: SCAN_MASK_EN (per-channel enable mask, skips
// disabled channels, disabled bits read back as 0).
// Ports:
//   i_clk, i_rst : clock and synchronous active-high reset
//   i_start      : scan request, honoured only while idle
//   i_dwell      : settle cycles per channel, latched at start
//   i_mask       : channel enables, latched at start (SCAN_MASK_EN only)
//   o_sel        : mux select
//   i_y_in       : mux output
//   o_busy       : scan in progress
//   o_done       : one-cycle completion pulse
//   o_data_out   : snapshot of the last completed scan
module mux_scan_controller
  import mux_scan_controller_pkg::*;
#(
  parameter int unsigned DWELL_W = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [DWELL_W-1:0] i_dwell,
`ifdef SCAN_MASK_EN
  input  logic [NUM_CH-1:0]  i_mask,
`endif
  output logic [SEL_W-1:0]   o_sel,
  input  logic               i_y_in,
  output logic               o_busy,
  output logic               o_done,
  output logic [NUM_CH-1:0]  o_data_out
);

  logic [1:0]         r_state;
  logic [DWELL_W-1:0] r_cnt;
  logic [DWELL_W-1:0] r_d;
  logic [SEL_W-1:0]   r_sel;
  logic               r_busy;
  logic               r_done;
  logic [NUM_CH-1:0]  r_shadow;
  logic [NUM_CH-1:0]  r_data;

  logic [SEL_W-1:0]   w_next;
  logic               w_last;
  logic [NUM_CH-1:0]  w_merged;
  logic [NUM_CH-1:0]  w_scan_word;
  logic [SEL_W-1:0]   w_first;
  logic               w_skip_settle;

`ifdef SCAN_MASK_EN
  logic [NUM_CH-1:0]  r_mask;

  scan_next_ch u_next_ch (
    .i_sel  (r_sel),
    .i_mask (r_mask),
    .o_next (w_next),
    .o_last (w_last)
  );

  assign w_first       = first_ch(i_mask);
  // An empty mask goes straight to SAMPLE, which then completes immediately
  // because no channel follows; the mask below forces the word to zero.
  assign w_skip_settle = (i_dwell == '0) || (i_mask == '0);
  // Shadow bits of disabled channels may be stale from earlier scans.
  assign w_scan_word   = w_merged & r_mask;
`else
  scan_next_ch u_next_ch (
    .i_sel  (r_sel),
    .o_next (w_next),
    .o_last (w_last)
  );

  assign w_first       = '0;
  assign w_skip_settle = (i_dwell == '0);
  assign w_scan_word   = w_merged;
`endif

  // Shadow with the current sample folded in, so the last channel lands in
  // the published word in the same cycle it is sampled.
  always_comb begin
    w_merged        = r_shadow;
    w_merged[r_sel] = i_y_in;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_d      <= '0;
      r_sel    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_shadow <= '0;
      r_data   <= '0;
`ifdef SCAN_MASK_EN
      r_mask   <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_d     <= i_dwell;
            r_cnt   <= i_dwell;
            r_sel   <= w_first;
            r_busy  <= 1'b1;
            r_state <= w_skip_settle ? ST_SAMPLE : ST_SETTLE;
`ifdef SCAN_MASK_EN
            r_mask  <= i_mask;
`endif
          end
        end
        ST_SETTLE: begin
          r_cnt <= r_cnt - DWELL_W'(1);
          if (r_cnt == DWELL_W'(1)) r_state <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          r_shadow <= w_merged;
          if (w_last) begin
            r_data  <= w_scan_word;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_sel   <= w_next;
            r_cnt   <= r_d;
            r_state <= (r_d == '0) ? ST_SAMPLE : ST_SETTLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_sel      = r_sel;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_data_out = r_data;

endmodule

// File: tb/tb_mux_scan_controller.sv
// Self-checking bench for mux_scan_controller. The reference model derives
// the channel visit list, per-channel hold time, scan length and expected
// snapshot straight from the mask, dwell and y_in pattern.
// Honours SCAN_MASK_EN when defined.
module tb_mux_scan_controller;

  localparam int DWELL_W = 8;

  logic               i_clk;
  logic               i_rst;
  logic               i_start;
  logic [DWELL_W-1:0] i_dwell;
`ifdef SCAN_MASK_EN
  logic [15:0]        i_mask;
`endif
  logic [3:0]         o_sel;
  logic               i_y_in;
  logic               o_busy;
  logic               o_done;
  logic [15:0]        o_data_out;

  logic [15:0]        pattern;
  logic [15:0]        exp_prev;
  int                 n_vec;
  int                 n_err;

  mux_scan_controller #(
    .DWELL_W (DWELL_W)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_dwell    (i_dwell),
`ifdef SCAN_MASK_EN
    .i_mask     (i_mask),
`endif
    .o_sel      (o_sel),
    .i_y_in     (i_y_in),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_data_out (o_data_out)
  );

  // The mux itself: y_in follows the pattern bit picked by the select.
  assign i_y_in = pattern[o_sel];

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // One full scan, checked cycle by cycle. Cycle k is sampled 1 time unit
  // after the k-th rising edge following the accept edge (k=0).
  task automatic run_scan(input int d, input logic [15:0] m, input logic [15:0] pat,
                          input int mid_k, input bit pre_started, input bit chain,
                          input int chain_d);
    int          chans[$];
    int          total;
    logic [15:0] exp_data;
    chans = {};
    for (int ch = 0; ch < 16; ch++) if (m[ch]) chans.push_back(ch);
    total    = (chans.size() == 0) ? 1 : chans.size() * (d + 1);
    exp_data = pat & m;
    pattern  = pat;
    if (!pre_started) begin
      @(negedge i_clk);
      i_dwell = d[DWELL_W-1:0];
`ifdef SCAN_MASK_EN
      i_mask  = m;
`endif
      i_start = 1'b1;
    end
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    for (int k = 0; k <= total; k++) begin
      if (k > 0) begin
        @(posedge i_clk);
        #1;
      end
      if (k < total) begin
        n_vec++;
        if (o_busy !== 1'b1) begin
          n_err++;
          $display("FAIL scan_busy d=%0d k=%0d: got %b want 1", d, k, o_busy);
        end
        n_vec++;
        if (o_done !== 1'b0) begin
          n_err++;
          $display("FAIL scan_done_early d=%0d k=%0d: got %b want 0", d, k, o_done);
        end
        n_vec++;
        if (o_data_out !== exp_prev) begin
          n_err++;
          $display("FAIL scan_data_held d=%0d k=%0d: got %h want %h", d, k, o_data_out,
                   exp_prev);
        end
        if (chans.size() > 0) begin
          n_vec++;
          if (o_sel !== 4'(chans[k / (d + 1)])) begin
            n_err++;
            $display("FAIL scan_sel d=%0d k=%0d: got %0d want %0d", d, k, o_sel,
                     chans[k / (d + 1)]);
          end
        end
      end else begin
        n_vec++;
        if (o_done !== 1'b1) begin
          n_err++;
          $display("FAIL scan_done d=%0d k=%0d: got %b want 1", d, k, o_done);
        end
        n_vec++;
        if (o_busy !== 1'b0) begin
          n_err++;
          $display("FAIL scan_busy_end d=%0d k=%0d: got %b want 0", d, k, o_busy);
        end
        n_vec++;
        if (o_data_out !== exp_data) begin
          n_err++;
          $display("FAIL scan_data d=%0d m=%h: got %h want %h", d, m, o_data_out, exp_data);
        end
        if (chans.size() > 0) begin
          n_vec++;
          if (o_sel !== 4'(chans[chans.size() - 1])) begin
            n_err++;
            $display("FAIL scan_sel_end d=%0d: got %0d want %0d", d, o_sel,
                     chans[chans.size() - 1]);
          end
        end
        exp_prev = exp_data;
      end
      // Stray start mid-scan (with a different dwell) must be ignored;
      // a start in the done cycle chains the next scan.
      i_start = ((k == mid_k) && (k < total)) || (chain && (k == total));
      if (i_start) begin
        if (k == total) i_dwell = chain_d[DWELL_W-1:0];
        else i_dwell = DWELL_W'($urandom);
      end
    end
  endtask

  task automatic check_idle(input string name, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(posedge i_clk);
      #1;
      n_vec++;
      if (o_busy !== 1'b0 || o_done !== 1'b0 || o_data_out !== exp_prev) begin
        n_err++;
        $display("FAIL %s c=%0d: got busy=%b done=%b data=%h want 0 0 %h", name, c,
                 o_busy, o_done, o_data_out, exp_prev);
      end
    end
  endtask

  task automatic test_reset();
    i_rst   = 1'b1;
    i_start = 1'b0;
    i_dwell = '0;
`ifdef SCAN_MASK_EN
    i_mask  = '0;
`endif
    pattern  = 16'h0;
    exp_prev = 16'h0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge i_clk);
      #1;
      n_vec++;
      if (o_sel !== 4'd0 || o_busy !== 1'b0 || o_done !== 1'b0 || o_data_out !== 16'h0) begin
        n_err++;
        $display("FAIL reset_idle c=%0d: got sel=%0d busy=%b done=%b data=%h want all 0", c,
                 o_sel, o_busy, o_done, o_data_out);
      end
    end
  endtask

  task automatic test_pattern_d0();
    run_scan(0, 16'hFFFF, 16'hA5C3, -1, 1'b0, 1'b0, 0);
  endtask

  task automatic test_dwell3_ignore_start();
    run_scan(3, 16'hFFFF, 16'h8001, 21, 1'b0, 1'b0, 0);
    check_idle("after_dwell3", 3);
  endtask

  task automatic test_reset_mid_scan();
    pattern = 16'h5A5A;
    @(negedge i_clk);
    i_dwell = 8'd2;
`ifdef SCAN_MASK_EN
    i_mask  = 16'hFFFF;
`endif
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge i_clk);
      #1;
    end
    n_vec++;
    if (o_busy !== 1'b1 || o_sel !== 4'd6) begin
      n_err++;
      $display("FAIL midscan_state: got busy=%b sel=%0d want 1 6", o_busy, o_sel);
    end
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    n_vec++;
    if (o_sel !== 4'd0 || o_busy !== 1'b0 || o_done !== 1'b0 || o_data_out !== 16'h0) begin
      n_err++;
      $display("FAIL midscan_reset: got sel=%0d busy=%b done=%b data=%h want all 0", o_sel,
               o_busy, o_done, o_data_out);
    end
    exp_prev = 16'h0;
    check_idle("post_reset_no_done", 60);
    run_scan(2, 16'hFFFF, 16'h3C96, -1, 1'b0, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    run_scan(1, 16'hFFFF, 16'(($urandom)), -1, 1'b0, 1'b1, 2);
    run_scan(2, 16'hFFFF, 16'(($urandom)), -1, 1'b1, 1'b1, 0);
    run_scan(0, 16'hFFFF, 16'(($urandom)), -1, 1'b1, 1'b0, 0);
    check_idle("after_b2b", 2);
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      logic [15:0] m;
`ifdef SCAN_MASK_EN
      m = 16'($urandom);
`else
      m = 16'hFFFF;
`endif
      run_scan(int'($urandom_range(0, 6)), m, 16'($urandom), int'($urandom_range(0, 15)),
               1'b0, 1'b0, 0);
    end
  endtask

  task automatic test_long_dwell();
    run_scan(255, 16'hFFFF, 16'h1234, 1000, 1'b0, 1'b0, 0);
  endtask

`ifdef SCAN_MASK_EN
  task automatic test_mask();
    run_scan(1, 16'h0101, 16'hFFFF, -1, 1'b0, 1'b0, 0);
    run_scan(3, 16'h0000, 16'hFFFF, -1, 1'b0, 1'b0, 0);
    run_scan(0, 16'h8000, 16'hFFFF, -1, 1'b0, 1'b1, 2);
    run_scan(2, 16'h8000, 16'h7FFF, -1, 1'b1, 1'b0, 0);
  endtask
`endif

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_pattern_d0();
    test_dwell3_ignore_start();
    test_reset_mid_scan();
    test_back_to_back();
    test_random();
    test_long_dwell();
`ifdef SCAN_MASK_EN
    test_mask();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
